y86_wb_regfile: RTL and testbench

//  Parametrised Y86 writeback stage merged with the architectural register file.

---
 rtl/y86_wb_regfile.sv | 170 +++++++++++++++++
 tb/tb_y86_wb_regfile.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/y86_wb_regfile.sv
// Y86 writeback stage merged with the architectural register file, busy scoreboard and clear sequencer.
// Optional feature: define WB_BYPASS_EN to forward same-cycle accepted writes to the read ports.
module y86_wb_regfile #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned NREG   = 15,
    parameter int unsigned RID_W  = 4,
    parameter int unsigned RSP_ID = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [3:0]        icode,
    input  logic              cnd,
    input  logic [RID_W-1:0]  ra,
    input  logic [RID_W-1:0]  rb,
    input  logic [DATA_W-1:0] val_e,
    input  logic [DATA_W-1:0] val_m,
    input  logic [RID_W-1:0]  rd_a_id,
    output logic [DATA_W-1:0] rd_a_data,
    input  logic [RID_W-1:0]  rd_b_id,
    output logic [DATA_W-1:0] rd_b_data,
    input  logic              rsv_valid,
    input  logic [RID_W-1:0]  rsv_id,
    output logic [NREG-1:0]   busy_vec
);

    typedef enum logic {StClear, StRun} state_e;

    state_e             state_q, state_d;
    logic [RID_W-1:0]   clr_idx_q, clr_idx_d;
    logic [NREG-1:0]    busy_q, busy_d;
    logic [DATA_W-1:0]  regs_q [NREG];

    logic               accept;
    logic               e_hit, e_cond, m_hit;
    logic [RID_W-1:0]   e_id, m_id;
    logic               e_wr, m_wr, e_clr;

    function automatic logic id_ok(input logic [RID_W-1:0] id);
        return (id != '1) && (32'(id) < NREG);
    endfunction

    assign wb_ready = (state_q == StRun);
    assign accept   = wb_valid && wb_ready;
    assign busy_vec = busy_q;

    // e_hit marks an instruction that names a valE destination even if cnd cancels the write.
    always_comb begin
        e_hit  = 1'b0;
        e_cond = 1'b1;
        e_id   = '1;
        m_hit  = 1'b0;
        m_id   = '1;
        case (icode)
            4'h2: begin
                e_hit  = 1'b1;
                e_cond = cnd;
                e_id   = rb;
            end
            4'h3, 4'h6: begin
                e_hit = 1'b1;
                e_id  = rb;
            end
            4'h5: begin
                m_hit = 1'b1;
                m_id  = ra;
            end
            4'h8, 4'h9, 4'hA: begin
                e_hit = 1'b1;
                e_id  = RID_W'(RSP_ID);
            end
            4'hB: begin
                e_hit = 1'b1;
                e_id  = RID_W'(RSP_ID);
                m_hit = 1'b1;
                m_id  = ra;
            end
            default: ;
        endcase
    end

    assign e_clr = accept && e_hit && id_ok(e_id);
    assign e_wr  = e_clr && e_cond;
    assign m_wr  = accept && m_hit && id_ok(m_id);

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        busy_d    = busy_q;
        case (state_q)
            StClear: begin
                clr_idx_d = clr_idx_q + RID_W'(1);
                if (clr_idx_q == RID_W'(NREG - 1)) begin
                    state_d   = StRun;
                    clr_idx_d = '0;
                end
            end
            StRun: begin
                for (int i = 0; i < NREG; i++) begin
                    if ((e_clr && e_id == RID_W'(i)) || (m_wr && m_id == RID_W'(i))) begin
                        busy_d[i] = 1'b0;
                    end
                    // Reservation applied last so a same-cycle set beats the clear.
                    if (rsv_valid && id_ok(rsv_id) && rsv_id == RID_W'(i)) begin
                        busy_d[i] = 1'b1;
                    end
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StClear;
            clr_idx_q <= '0;
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            busy_q    <= busy_d;
        end
    end

    // The array itself is zeroed by the clear sequencer rather than by reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NREG; i++) begin
            if (state_q == StClear) begin
                if (clr_idx_q == RID_W'(i)) begin
                    regs_q[i] <= '0;
                end
            end else if (m_wr && m_id == RID_W'(i)) begin
                regs_q[i] <= val_m;
            end else if (e_wr && e_id == RID_W'(i)) begin
                regs_q[i] <= val_e;
            end
        end
    end

    always_comb begin
        rd_a_data = '0;
        rd_b_data = '0;
        if (state_q == StRun) begin
            for (int i = 0; i < NREG; i++) begin
                if (id_ok(rd_a_id) && rd_a_id == RID_W'(i)) begin
                    rd_a_data = regs_q[i];
                end
                if (id_ok(rd_b_id) && rd_b_id == RID_W'(i)) begin
                    rd_b_data = regs_q[i];
                end
            end
`ifdef WB_BYPASS_EN
            if (e_wr && e_id == rd_a_id) begin
                rd_a_data = val_e;
            end
            if (m_wr && m_id == rd_a_id) begin
                rd_a_data = val_m;
            end
            if (e_wr && e_id == rd_b_id) begin
                rd_b_data = val_e;
            end
            if (m_wr && m_id == rd_b_id) begin
                rd_b_data = val_m;
            end
`endif
        end
    end

endmodule

// File: tb/tb_y86_wb_regfile.sv
// Directed self-checking bench for y86_wb_regfile (honours WB_BYPASS_EN when defined).
module tb_y86_wb_regfile;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned NREG   = 15;
    localparam int unsigned RID_W  = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              wb_valid = 1'b0;
    logic              wb_ready;
    logic [3:0]        icode = 4'h0;
    logic              cnd = 1'b0;
    logic [RID_W-1:0]  ra = 4'hF;
    logic [RID_W-1:0]  rb = 4'hF;
    logic [DATA_W-1:0] val_e = '0;
    logic [DATA_W-1:0] val_m = '0;
    logic [RID_W-1:0]  rd_a_id = 4'h0;
    logic [DATA_W-1:0] rd_a_data;
    logic [RID_W-1:0]  rd_b_id = 4'h0;
    logic [DATA_W-1:0] rd_b_data;
    logic              rsv_valid = 1'b0;
    logic [RID_W-1:0]  rsv_id = 4'hF;
    logic [NREG-1:0]   busy_vec;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clock = ~clock;

    y86_wb_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .RID_W  (RID_W),
        .RSP_ID (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .icode     (icode),
        .cnd       (cnd),
        .ra        (ra),
        .rb        (rb),
        .val_e     (val_e),
        .val_m     (val_m),
        .rd_a_id   (rd_a_id),
        .rd_a_data (rd_a_data),
        .rd_b_id   (rd_b_id),
        .rd_b_data (rd_b_data),
        .rsv_valid (rsv_valid),
        .rsv_id    (rsv_id),
        .busy_vec  (busy_vec)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Read register id on both ports and compare each against exp.
    task automatic rd_chk(input string tag, input logic [3:0] id, input logic [63:0] exp);
        rd_a_id = id;
        rd_b_id = id;
        #1;
        check({tag, "_a"}, rd_a_data, exp);
        check({tag, "_b"}, rd_b_data, exp);
    endtask

    // One accepted writeback; called at a negedge, returns at the following negedge.
    task automatic wb(input logic [3:0] ic, input logic c, input logic [3:0] a,
                      input logic [3:0] b, input logic [63:0] ve, input logic [63:0] vm);
        icode    = ic;
        cnd      = c;
        ra       = a;
        rb       = b;
        val_e    = ve;
        val_m    = vm;
        wb_valid = 1'b1;
        @(negedge clock);
        wb_valid  = 1'b0;
        rsv_valid = 1'b0;
        #1;
    endtask

    // Release reset and count cycles with wb_ready low (bounded).
    task automatic release_and_count(input string tag);
        int lows;
        lows  = 0;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 40 && !wb_ready; i++) begin
            if (i == 3) rd_chk({tag, "_clr_rd"}, 4'h0, 64'h0);
            lows++;
            @(negedge clock);
            #1;
        end
        check({tag, "_ready_lows"}, 64'(lows), 64'd15);
        check({tag, "_ready"}, 64'(wb_ready), 64'd1);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        #1;
        check("rst_ready", 64'(wb_ready), 64'd0);
        check("rst_busy", 64'(busy_vec), 64'd0);
        rd_chk("rst_rd", 4'h2, 64'h0);
        release_and_count("clr1");
        check("clr1_busy", 64'(busy_vec), 64'd0);
        rd_chk("clr1_r5", 4'h5, 64'h0);

        // irmov r2: visible next cycle (same cycle with bypass)
        icode = 4'h3; rb = 4'h2; val_e = 64'h1234; wb_valid = 1'b1;
        rd_a_id = 4'h2;
        #1;
`ifdef WB_BYPASS_EN
        check("irmov_same", rd_a_data, 64'h1234);
`else
        check("irmov_same", rd_a_data, 64'h0);
`endif
        @(negedge clock);
        wb_valid = 1'b0;
        #1;
        rd_chk("irmov_next", 4'h2, 64'h1234);

        // Cancelled cmov keeps r3 but clears its busy bit
        wb(4'h3, 1'b0, 4'hF, 4'h3, 64'h5, 64'h0);
        rsv_valid = 1'b1; rsv_id = 4'h3;
        @(negedge clock);
        rsv_valid = 1'b0;
        #1;
        check("rsv3", 64'(busy_vec[3]), 64'd1);
        rsv_valid = 1'b1; rsv_id = 4'h3;
        @(negedge clock);
        rsv_valid = 1'b0;
        #1;
        check("rsv3_double", 64'(busy_vec[3]), 64'd1);
        wb(4'h2, 1'b0, 4'hF, 4'h3, 64'hFF, 64'h0);
        rd_chk("cmov_off", 4'h3, 64'h5);
        check("cmov_off_busy", 64'(busy_vec[3]), 64'd0);
        wb(4'h2, 1'b1, 4'hF, 4'h3, 64'hFF, 64'h0);
        rd_chk("cmov_on", 4'h3, 64'hFF);

        // popq %rsp: val_m wins; then popq r1
        wb(4'hB, 1'b0, 4'h4, 4'hF, 64'h100, 64'hABC);
        rd_chk("pop_rsp", 4'h4, 64'hABC);
        wb(4'hB, 1'b0, 4'h1, 4'hF, 64'h100, 64'hABC);
        rd_chk("pop_r4", 4'h4, 64'h100);
        rd_chk("pop_r1", 4'h1, 64'hABC);

        // Reserve and write r6 same cycle: set wins
        rsv_valid = 1'b1; rsv_id = 4'h6;
        wb(4'h6, 1'b0, 4'hF, 4'h6, 64'h66, 64'h0);
        check("rsv6_win", 64'(busy_vec[6]), 64'd1);
        rd_chk("opq_r6", 4'h6, 64'h66);

        // Reserve of id F ignored
        rsv_valid = 1'b1; rsv_id = 4'hF;
        @(negedge clock);
        rsv_valid = 1'b0;
        #1;
        check("rsv_f", 64'(busy_vec), 64'h0040);

        // mrmov, call, halt (no write), dest F dropped, read of F
        wb(4'h5, 1'b0, 4'h7, 4'hF, 64'h1, 64'h77);
        rd_chk("mrmov_r7", 4'h7, 64'h77);
        wb(4'h8, 1'b0, 4'hF, 4'hF, 64'h200, 64'h0);
        rd_chk("call_rsp", 4'h4, 64'h200);
        wb(4'h0, 1'b1, 4'h7, 4'h7, 64'hDEAD, 64'hBEEF);
        rd_chk("halt_r7", 4'h7, 64'h77);
        wb(4'h3, 1'b0, 4'hF, 4'hF, 64'h999, 64'h0);
        rd_chk("drop_rf", 4'hF, 64'h0);
        rd_chk("drop_r0", 4'h0, 64'h0);

        // Reset mid-RUN with a request held through the clear
        reset = 1'b1;
        #1;
        check("rst2_ready", 64'(wb_ready), 64'd0);
        check("rst2_busy", 64'(busy_vec), 64'd0);
        rd_chk("rst2_rd", 4'h4, 64'h0);
        icode = 4'h3; rb = 4'h5; val_e = 64'h55; wb_valid = 1'b1;
        repeat (2) @(negedge clock);
        release_and_count("clr2");
        check("clr2_busy", 64'(busy_vec), 64'd0);
        rd_chk("clr2_r4", 4'h4, 64'h0);
        rd_chk("clr2_r1", 4'h1, 64'h0);
        rd_chk("clr2_r6", 4'h6, 64'h0);
        @(negedge clock);
        wb_valid = 1'b0;
        #1;
        rd_chk("held_r5", 4'h5, 64'h55);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
